scr1_tcm_sp_arbiter: RTL and testbench
======================================

// Module: scr1_tcm_sp_arbiter
// PURPOSE
//  Shares one single-port 32-bit synchronous RAM (1-cycle read latency, byte-enable writes) between the core
//  imem and dmem interfaces. Drop-in TCM replacement on FPGAs where a true dual-port RAM with byte enables is
//  not available. Speaks the SCR1 memory protocol (req/req_ack handshake, resp one cycle later) on both core sides.
//  Grants one access per cycle.
// PARAMETERS
//  SCR1_TCM_SIZE  32'h00010000  TCM size in bytes (power of 2). Memory word address width is $clog2(SIZE)-2.
//  ARB_MODE       0             0 = round-robin on conflict; 1 = dmem fixed priority with imem anti-starvation.
//  MAX_WAIT       4             ARB_MODE=1 only: consecutive imem denials before imem is forced (1..15).
// PORTS
//  clk           in   1    core clock
//  rst_n         in   1    asynchronous active-low reset
//  imem_req      in   1    instruction fetch request
//  imem_req_ack  out  1    fetch accepted this cycle (combinational)
//  imem_addr     in   32   byte address; bits [1:0] ignored
//  imem_rdata    out  32   fetch data, valid when imem_resp=RDY_OK
//  imem_resp     out  2    type_scr1_mem_resp_e
//  dmem_req      in   1    data request
//  dmem_req_ack  out  1    data request accepted this cycle (combinational)
//  dmem_cmd      in   1    type_scr1_mem_cmd_e (RD/WR)
//  dmem_width    in   2    type_scr1_mem_width_e (BYTE/HWORD/WORD)
//  dmem_addr     in   32   byte address
//  dmem_wdata    in   32   write data, LSB-aligned
//  dmem_rdata    out  32   read data, right-shifted by 8*addr[1:0]
//  dmem_resp     out  2    type_scr1_mem_resp_e
//  mem_en        out  1    RAM access strobe
//  mem_we        out  1    RAM write (qualified by mem_en)
//  mem_be        out  4    RAM byte enables
//  mem_addr      out  $clog2(SIZE)-2  RAM word address
//  mem_wdata     out  32   RAM write data, lane-replicated
//  mem_rdata     in   32   RAM read data, valid the cycle after mem_en & ~mem_we
// BEHAVIOUR
//  Reset: imem_resp/dmem_resp=NOTRDY, imem_rdata/dmem_rdata=0, last_grant=IMEM, wait_cnt=0, resp pipeline empty.
//   mem_en/mem_we/req_acks=0 while rst_n low.
//  Grant (combinational): one requester only -> granted. Both requesting:
//   ARB_MODE=0: grant opposite of last_grant. ARB_MODE=1: dmem, unless wait_cnt==MAX_WAIT -> imem.
//  req_ack = grant for that requester. Handshake completes on req & req_ack. Ungranted requester sees req_ack=0
//   and must hold req/addr/cmd/wdata stable. Accepted transaction drives mem_* that same cycle.
//  last_grant updates only on an actual grant. wait_cnt: +1 when imem_req & ~imem grant, saturates at MAX_WAIT;
//   cleared on imem grant.
//  Address check: addr >= SCR1_TCM_SIZE -> request still acked, mem_en=0, resp=RDY_ER next cycle, rdata=0.
//  Write lanes: BYTE -> wdata[7:0] x4, be=4'b0001<<addr[1:0]. HWORD -> wdata[15:0] x2, be=4'b0011<<{addr[1],0}.
//   WORD -> be=4'b1111. imem: mem_we=0, be=4'b1111.
//  Misaligned dmem (HWORD with addr[0]=1, WORD with addr[1:0]!=0) -> RDY_ER, no memory access.
//  Response: cycle N+1 after accept in cycle N, the owner gets resp=RDY_OK/RDY_ER for exactly one cycle;
//   otherwise NOTRDY. Read data is taken from mem_rdata in N+1, dmem shifted by the addr[1:0] registered at N.
//   rdata holds its last value when resp=NOTRDY. Back-to-back accepts are allowed every cycle, so throughput is
//   1 access/cycle total.
//  Simultaneous: resp for one requester in N+1 and accept of the other in N+1 are independent.
//   Never two grants in one cycle.
//  Reset mid-operation: a pending response is dropped. After deassertion the first cycle is idle-ready
//   (acks allowed).
// STRUCTURE
//  Shared include/package: type_scr1_tcm_grant_e {SCR1_TCM_GRANT_NONE, _IMEM, _DMEM}.
//   The memif enums come from scr1_memif.svh.
//  Sub-module scr1_tcm_arb2: 2-way arbiter with last_grant register, wait counter, ARB_MODE/MAX_WAIT; outputs
//   one-hot grant. Top level: lane formatting, address/alignment check, response pipeline register
//   {owner, err, shift}.
// TESTING
//  imem-only fetch at 0x100, RAM word 0xDEADBEEF -> ack same cycle, next cycle imem_resp=RDY_OK,
//   imem_rdata=0xDEADBEEF.
//  dmem SB 0xA5 at 0x203, then LW 0x200 -> mem_be=4'b1000; read returns 0xA5xxxxxx; LB 0x203 -> dmem_rdata[7:0]=0xA5.
//  Both req every cycle, ARB_MODE=0, 8 cycles -> grants alternate I,D,I,D...; 4 resp each, none lost.
//  ARB_MODE=1, MAX_WAIT=4, both req continuously -> grants D,D,D,D,I,D,D,D,D,I; wait_cnt returns to 0 after I.
//  dmem LW at 0x00010000 (SIZE=64K) and LH at 0x101 -> mem_en=0, dmem_resp=RDY_ER next cycle, dmem_rdata=0.
//  Assert rst_n low in the cycle after accept -> no RDY_OK emitted; resps NOTRDY; first post-reset request
//   served normally.

Source files
------------

// File: rtl/scr1_tcm_sp_arbiter_pkg.sv
// rtl/scr1_tcm_sp_arbiter_pkg.sv - memory interface enums, grant type and lane helpers for the shared TCM
package scr1_tcm_sp_arbiter_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_TCM_GRANT_NONE = 2'b00,
    SCR1_TCM_GRANT_IMEM = 2'b01,
    SCR1_TCM_GRANT_DMEM = 2'b10
  } type_scr1_tcm_grant_e;

  function automatic logic [3:0] scr1_tcm_byte_en(input type_scr1_mem_width_e width,
                                                  input logic [1:0] offs);
    logic [3:0] be;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << offs;
      SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << {offs[1], 1'b0};
      default:              be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the LSB-aligned write data across all lanes so byte enables alone pick the target.
  function automatic logic [31:0] scr1_tcm_lane_data(input type_scr1_mem_width_e width,
                                                     input logic [31:0] wdata);
    logic [31:0] d;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  d = {4{wdata[7:0]}};
      SCR1_MEM_WIDTH_HWORD: d = {2{wdata[15:0]}};
      default:              d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/scr1_tcm_arb2.sv
// rtl/scr1_tcm_arb2.sv - two-way imem/dmem arbiter with round-robin or dmem-priority anti-starvation
module scr1_tcm_arb2
  import scr1_tcm_sp_arbiter_pkg::*;
#(
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       imem_req,
  input  logic       dmem_req,
  output logic [1:0] grant
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  type_scr1_tcm_grant_e last_grant;
  logic [3:0]           wait_cnt;

  // grant is one-hot {dmem, imem}
  always_comb begin
    grant = 2'b00;
    if (imem_req && dmem_req) begin
      if (ARB_MODE == 0) begin
        grant = (last_grant == SCR1_TCM_GRANT_IMEM) ? 2'b10 : 2'b01;
      end else begin
        grant = (wait_cnt == WAIT_MAX) ? 2'b01 : 2'b10;
      end
    end else if (imem_req) begin
      grant = 2'b01;
    end else if (dmem_req) begin
      grant = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SCR1_TCM_GRANT_IMEM;
      wait_cnt   <= 4'd0;
    end else begin
      if (grant[0]) begin
        last_grant <= SCR1_TCM_GRANT_IMEM;
      end else if (grant[1]) begin
        last_grant <= SCR1_TCM_GRANT_DMEM;
      end
      if (grant[0]) begin
        wait_cnt <= 4'd0;
      end else if (imem_req && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/scr1_tcm_sp_arbiter.sv
// rtl/scr1_tcm_sp_arbiter.sv - single-port TCM shared between imem and dmem, one access per cycle
module scr1_tcm_sp_arbiter
  import scr1_tcm_sp_arbiter_pkg::*;
#(
  parameter logic [31:0] SCR1_TCM_SIZE = 32'h00010000,
  parameter int          ARB_MODE      = 0,
  parameter int          MAX_WAIT      = 4,
  localparam int         AW            = $clog2(SCR1_TCM_SIZE) - 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 imem_req,
  output logic                 imem_req_ack,
  input  logic [31:0]          imem_addr,
  output logic [31:0]          imem_rdata,
  output type_scr1_mem_resp_e  imem_resp,
  input  logic                 dmem_req,
  output logic                 dmem_req_ack,
  input  type_scr1_mem_cmd_e   dmem_cmd,
  input  type_scr1_mem_width_e dmem_width,
  input  logic [31:0]          dmem_addr,
  input  logic [31:0]          dmem_wdata,
  output logic [31:0]          dmem_rdata,
  output type_scr1_mem_resp_e  dmem_resp,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [AW-1:0]        mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  logic       imem_req_v;
  logic       dmem_req_v;
  logic [1:0] grant;
  logic       imem_err;
  logic       dmem_misalign;
  logic       dmem_err;

  // Masking requests with rst_n keeps acks and RAM strobes low for the whole reset window.
  assign imem_req_v = imem_req & rst_n;
  assign dmem_req_v = dmem_req & rst_n;

  scr1_tcm_arb2 #(
    .ARB_MODE (ARB_MODE),
    .MAX_WAIT (MAX_WAIT)
  ) i_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .imem_req (imem_req_v),
    .dmem_req (dmem_req_v),
    .grant    (grant)
  );

  assign imem_req_ack = grant[0];
  assign dmem_req_ack = grant[1];

  always_comb begin
    dmem_misalign = 1'b0;
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE:  dmem_misalign = 1'b0;
      SCR1_MEM_WIDTH_HWORD: dmem_misalign = dmem_addr[0];
      SCR1_MEM_WIDTH_WORD:  dmem_misalign = |dmem_addr[1:0];
      default:              dmem_misalign = 1'b1;
    endcase
  end

  assign imem_err = (imem_addr >= SCR1_TCM_SIZE);
  assign dmem_err = (dmem_addr >= SCR1_TCM_SIZE) | dmem_misalign;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b1111;
    mem_addr  = imem_addr[AW+1:2];
    mem_wdata = scr1_tcm_lane_data(dmem_width, dmem_wdata);
    if (grant[0]) begin
      mem_en = ~imem_err;
    end else if (grant[1]) begin
      mem_en   = ~dmem_err;
      mem_we   = ~dmem_err & (dmem_cmd == SCR1_MEM_CMD_WR);
      mem_be   = scr1_tcm_byte_en(dmem_width, dmem_addr[1:0]);
      mem_addr = dmem_addr[AW+1:2];
    end
  end

  // Response pipeline: which side owns next cycle's response, and how to present its data.
  type_scr1_tcm_grant_e resp_owner;
  logic                 resp_err;
  logic                 resp_rd;
  logic [1:0]           resp_shift;
  logic [31:0]          imem_rdata_q;
  logic [31:0]          dmem_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_owner <= SCR1_TCM_GRANT_NONE;
      resp_err   <= 1'b0;
      resp_rd    <= 1'b0;
      resp_shift <= 2'b00;
    end else if (grant[0]) begin
      resp_owner <= SCR1_TCM_GRANT_IMEM;
      resp_err   <= imem_err;
      resp_rd    <= 1'b1;
      resp_shift <= 2'b00;
    end else if (grant[1]) begin
      resp_owner <= SCR1_TCM_GRANT_DMEM;
      resp_err   <= dmem_err;
      resp_rd    <= (dmem_cmd == SCR1_MEM_CMD_RD);
      resp_shift <= dmem_addr[1:0];
    end else begin
      resp_owner <= SCR1_TCM_GRANT_NONE;
    end
  end

  always_comb begin
    imem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    imem_rdata = imem_rdata_q;
    dmem_rdata = dmem_rdata_q;
    if (resp_owner == SCR1_TCM_GRANT_IMEM) begin
      imem_resp  = resp_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      imem_rdata = resp_err ? 32'd0 : mem_rdata;
    end else if (resp_owner == SCR1_TCM_GRANT_DMEM) begin
      dmem_resp = resp_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      if (resp_err) begin
        dmem_rdata = 32'd0;
      end else if (resp_rd) begin
        dmem_rdata = mem_rdata >> {resp_shift, 3'b000};
      end
    end
  end

  // Presented data is re-registered so it holds while the response is NOTRDY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rdata_q <= 32'd0;
      dmem_rdata_q <= 32'd0;
    end else begin
      imem_rdata_q <= imem_rdata;
      dmem_rdata_q <= dmem_rdata;
    end
  end

endmodule

// File: tb/tb_scr1_tcm_sp_arbiter.sv
// tb/tb_scr1_tcm_sp_arbiter.sv - randomized and directed bench for the shared single-port TCM arbiter
module tb_scr1_tcm_sp_arbiter;
  import scr1_tcm_sp_arbiter_pkg::*;

  localparam int AW   = 14;
  localparam int MAXW = 4;

  typedef struct {
    logic [31:0]          addr;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [31:0]          wdata;
  } tx_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n        [2];
  logic                 imem_req     [2];
  logic                 imem_req_ack [2];
  logic [31:0]          imem_addr    [2];
  logic [31:0]          imem_rdata   [2];
  type_scr1_mem_resp_e  imem_resp    [2];
  logic                 dmem_req     [2];
  logic                 dmem_req_ack [2];
  type_scr1_mem_cmd_e   dmem_cmd     [2];
  type_scr1_mem_width_e dmem_width   [2];
  logic [31:0]          dmem_addr    [2];
  logic [31:0]          dmem_wdata   [2];
  logic [31:0]          dmem_rdata   [2];
  type_scr1_mem_resp_e  dmem_resp    [2];
  logic                 mem_en       [2];
  logic                 mem_we       [2];
  logic [3:0]           mem_be       [2];
  logic [AW-1:0]        mem_addr     [2];
  logic [31:0]          mem_wdata    [2];
  logic [31:0]          mem_rdata    [2];

  scr1_tcm_sp_arbiter #(.SCR1_TCM_SIZE(32'h00010000), .ARB_MODE(0), .MAX_WAIT(MAXW)) dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .imem_req(imem_req[0]), .imem_req_ack(imem_req_ack[0]), .imem_addr(imem_addr[0]),
    .imem_rdata(imem_rdata[0]), .imem_resp(imem_resp[0]),
    .dmem_req(dmem_req[0]), .dmem_req_ack(dmem_req_ack[0]), .dmem_cmd(dmem_cmd[0]),
    .dmem_width(dmem_width[0]), .dmem_addr(dmem_addr[0]), .dmem_wdata(dmem_wdata[0]),
    .dmem_rdata(dmem_rdata[0]), .dmem_resp(dmem_resp[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_be(mem_be[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  scr1_tcm_sp_arbiter #(.SCR1_TCM_SIZE(32'h00010000), .ARB_MODE(1), .MAX_WAIT(MAXW)) dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .imem_req(imem_req[1]), .imem_req_ack(imem_req_ack[1]), .imem_addr(imem_addr[1]),
    .imem_rdata(imem_rdata[1]), .imem_resp(imem_resp[1]),
    .dmem_req(dmem_req[1]), .dmem_req_ack(dmem_req_ack[1]), .dmem_cmd(dmem_cmd[1]),
    .dmem_width(dmem_width[1]), .dmem_addr(dmem_addr[1]), .dmem_wdata(dmem_wdata[1]),
    .dmem_rdata(dmem_rdata[1]), .dmem_resp(dmem_resp[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_be(mem_be[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Synchronous single-port RAM per instance, 1-cycle read latency.
  logic [31:0] ram [2][1<<AW];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k]) begin
        if (mem_we[k]) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_be[k][b]) ram[k][mem_addr[k]][8*b +: 8] = mem_wdata[k][8*b +: 8];
          end
        end else begin
          mem_rdata[k] <= ram[k][mem_addr[k]];
        end
      end
    end
  end

  // Reference model: byte-addressed memory image plus arbitration rules.
  logic [7:0]  ref_mem [2][65536];
  int          m_last  [2];
  int          m_wait  [2];
  int          p_own   [2];
  logic        p_err   [2];
  logic [31:0] p_data  [2];
  logic        p_rd    [2];
  logic [31:0] e_ird   [2];
  logic [31:0] e_drd   [2];
  logic        e_dknown[2];

  tx_t         iq[$];
  tx_t         dq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hist;
  logic [3:0]  s_be;
  logic        s_en;
  logic        rst_mid = 1'b0;
  int          n_iresp = 0;
  int          n_dresp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int k, input logic [31:0] a);
    int b;
    b = int'({a[15:2], 2'b00});
    return {ref_mem[k][b+3], ref_mem[k][b+2], ref_mem[k][b+1], ref_mem[k][b]};
  endfunction

  function automatic tx_t mk(input logic [31:0] a, input type_scr1_mem_cmd_e c,
                             input type_scr1_mem_width_e w, input logic [31:0] d);
    tx_t t;
    t.addr = a; t.cmd = c; t.width = w; t.wdata = d;
    return t;
  endfunction

  task automatic model_reset(input int k);
    m_last[k] = 1; m_wait[k] = 0; p_own[k] = 0; p_err[k] = 1'b0; p_rd[k] = 1'b0; p_data[k] = '0;
    e_ird[k] = '0; e_drd[k] = '0; e_dknown[k] = 1'b1;
  endtask

  task automatic set_word(input int k, input int w, input logic [31:0] v);
    ram[k][w] = v;
    for (int b = 0; b < 4; b++) ref_mem[k][4*w+b] = v[8*b +: 8];
  endtask

  // One clock cycle on instance k; entered and left at a falling edge.
  task automatic step(input int k);
    type_scr1_mem_resp_e ei, ed;
    tx_t it, dt;
    logic ireq, dreq, err;
    logic [31:0] a;
    int eg, nb;
    ei = SCR1_MEM_RESP_NOTRDY;
    ed = SCR1_MEM_RESP_NOTRDY;
    if (p_own[k] == 1) begin
      ei = p_err[k] ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      e_ird[k] = p_data[k];
    end else if (p_own[k] == 2) begin
      ed = p_err[k] ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      e_dknown[k] = p_err[k] | p_rd[k];
      e_drd[k] = p_data[k];
    end
    if (imem_resp[k] != SCR1_MEM_RESP_NOTRDY) n_iresp++;
    if (dmem_resp[k] != SCR1_MEM_RESP_NOTRDY) n_dresp++;
    chk("imem_resp", 32'(imem_resp[k]), 32'(ei));
    chk("dmem_resp", 32'(dmem_resp[k]), 32'(ed));
    chk("imem_rdata", imem_rdata[k], e_ird[k]);
    if (e_dknown[k]) chk("dmem_rdata", dmem_rdata[k], e_drd[k]);
    p_own[k] = 0;

    ireq = (iq.size() != 0);
    dreq = (dq.size() != 0);
    it = ireq ? iq[0] : mk(32'd0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'd0);
    dt = dreq ? dq[0] : mk(32'd0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'd0);
    imem_req[k] = ireq; imem_addr[k] = it.addr;
    dmem_req[k] = dreq; dmem_addr[k] = dt.addr; dmem_cmd[k] = dt.cmd;
    dmem_width[k] = dt.width; dmem_wdata[k] = dt.wdata;
    #1;

    eg = 0;
    if (ireq && dreq) begin
      if (k == 0) eg = (m_last[k] == 1) ? 2 : 1;
      else        eg = (m_wait[k] == MAXW) ? 1 : 2;
    end else if (ireq) eg = 1;
    else if (dreq) eg = 2;
    if (eg == 1) m_wait[k] = 0;
    else if (ireq && m_wait[k] < MAXW) m_wait[k]++;
    if (eg != 0) begin
      m_last[k] = eg;
      hist = {hist[29:0], 2'(eg)};
      s_be = mem_be[k];
      s_en = mem_en[k];
    end
    chk("imem_req_ack", 32'(imem_req_ack[k]), 32'(eg == 1));
    chk("dmem_req_ack", 32'(dmem_req_ack[k]), 32'(eg == 2));

    err = 1'b0;
    if (eg == 1) begin
      a = it.addr;
      err = (a >= 32'h10000);
      p_own[k] = 1; p_err[k] = err; p_rd[k] = 1'b1;
      p_data[k] = err ? 32'd0 : ref_word(k, a);
      void'(iq.pop_front());
    end else if (eg == 2) begin
      a = dt.addr;
      err = (a >= 32'h10000) || (dt.width == SCR1_MEM_WIDTH_HWORD && a[0]) ||
            (dt.width == SCR1_MEM_WIDTH_WORD && a[1:0] != 2'b00);
      p_own[k] = 2; p_err[k] = err; p_rd[k] = (dt.cmd == SCR1_MEM_CMD_RD);
      p_data[k] = (err || !p_rd[k]) ? 32'd0 : (ref_word(k, a) >> (8 * int'(a[1:0])));
      if (!err && mem_en[k]) chk("mem_we", 32'(mem_we[k]), 32'(dt.cmd == SCR1_MEM_CMD_WR));
      if (!err && dt.cmd == SCR1_MEM_CMD_WR) begin
        nb = (dt.width == SCR1_MEM_WIDTH_BYTE) ? 1 : (dt.width == SCR1_MEM_WIDTH_HWORD) ? 2 : 4;
        for (int i = 0; i < nb; i++) ref_mem[k][int'(a[15:0]) + i] = dt.wdata[8*i +: 8];
      end
      void'(dq.pop_front());
    end
    chk("mem_en", 32'(mem_en[k]), 32'(eg != 0 && !err));
    if (eg != 0 && !err) chk("mem_addr", 32'(mem_addr[k]), 32'(a[15:2]));

    @(posedge clk);
    if (rst_mid) begin
      #1;
      rst_n[k] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run(input int k);
    int n;
    n = 0;
    while ((iq.size() != 0 || dq.size() != 0 || p_own[k] != 0) && n < 200) begin
      step(k);
      n++;
    end
    chk("run_drained", 32'(n < 200), 32'd1);
  endtask

  task automatic push_random(input int ni, input int nd);
    logic [31:0] a;
    for (int i = 0; i < ni; i++) begin
      a = 32'h200 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = 32'h10000 + 32'($urandom_range(0, 4095));
      iq.push_back(mk(a, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'd0));
    end
    for (int i = 0; i < nd; i++) begin
      a = 32'h200 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = 32'h10000 + 32'($urandom_range(0, 4095));
      dq.push_back(mk(a, type_scr1_mem_cmd_e'(1'($urandom_range(0, 1))),
                      type_scr1_mem_width_e'(2'($urandom_range(0, 2))), $urandom));
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < (1 << AW); w++) set_word(k, w, $urandom);
      rst_n[k] = 1'b0;
      imem_req[k] = 1'b1; imem_addr[k] = 32'h100;
      dmem_req[k] = 1'b1; dmem_addr[k] = 32'h200; dmem_cmd[k] = SCR1_MEM_CMD_RD;
      dmem_width[k] = SCR1_MEM_WIDTH_WORD; dmem_wdata[k] = 32'd0;
      model_reset(k);
    end
    set_word(0, 32'h40, 32'hDEADBEEF);
    hist = '0; s_be = '0; s_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state: requests held high, nothing may be acked or strobed.
    for (int k = 0; k < 2; k++) begin
      chk("rst_imem_ack", 32'(imem_req_ack[k]), 32'd0);
      chk("rst_dmem_ack", 32'(dmem_req_ack[k]), 32'd0);
      chk("rst_mem_en", 32'(mem_en[k]), 32'd0);
      chk("rst_imem_resp", 32'(imem_resp[k]), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("rst_dmem_resp", 32'(dmem_resp[k]), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("rst_imem_rdata", imem_rdata[k], 32'd0);
      chk("rst_dmem_rdata", dmem_rdata[k], 32'd0);
      imem_req[k] = 1'b0; dmem_req[k] = 1'b0;
      rst_n[k] = 1'b1;
    end
    @(negedge clk);

    // imem fetch from 0x100
    iq.push_back(mk(32'h100, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'd0));
    run(0);
    chk("fetch_deadbeef", imem_rdata[0], 32'hDEADBEEF);

    // SB 0xA5 @0x203, LW 0x200, LB 0x203
    dq.push_back(mk(32'h203, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h123456A5));
    run(0);
    chk("sb_be", 32'(s_be), 32'(4'b1000));
    dq.push_back(mk(32'h200, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'd0));
    run(0);
    chk("lw_top_byte", 32'(dmem_rdata[0][31:24]), 32'hA5);
    dq.push_back(mk(32'h203, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'd0));
    run(0);
    chk("lb_low_byte", 32'(dmem_rdata[0][7:0]), 32'hA5);

    // Round-robin conflict after a dmem grant: I,D,I,D,...
    for (int i = 0; i < 4; i++) begin
      iq.push_back(mk(32'h200 + 32'(4 * i), SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'd0));
      dq.push_back(mk(32'h210 + 32'(4 * i), SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'd0));
    end
    hist = '0; n_iresp = 0; n_dresp = 0;
    run(0);
    chk("rr_pattern", {16'd0, hist[15:0]}, 32'h6666);
    chk("rr_imem_resps", 32'(n_iresp), 32'd4);
    chk("rr_dmem_resps", 32'(n_dresp), 32'd4);

    // Out of range and misaligned dmem accesses
    dq.push_back(mk(32'h00010000, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'd0));
    run(0);
    chk("oor_mem_en", 32'(s_en), 32'd0);
    chk("oor_rdata", dmem_rdata[0], 32'd0);
    dq.push_back(mk(32'h203, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'd0));
    dq.push_back(mk(32'h101, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'd0));
    run(0);
    chk("mis_mem_en", 32'(s_en), 32'd0);
    chk("mis_rdata", dmem_rdata[0], 32'd0);

    // Reset asserted in the cycle after an accept drops the response
    iq.push_back(mk(32'h100, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'd0));
    rst_mid = 1'b1;
    step(0);
    rst_mid = 1'b0;
    model_reset(0);
    imem_req[0] = 1'b1;
    #1;
    chk("midrst_imem_resp", 32'(imem_resp[0]), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("midrst_imem_rdata", imem_rdata[0], 32'd0);
    chk("midrst_ack", 32'(imem_req_ack[0]), 32'd0);
    @(negedge clk);
    imem_req[0] = 1'b0;
    rst_n[0] = 1'b1;
    iq.push_back(mk(32'h100, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'd0));
    run(0);
    chk("post_rst_fetch", imem_rdata[0], 32'hDEADBEEF);

    // Fixed priority with anti-starvation on the second instance
    for (int i = 0; i < 8; i++)
      dq.push_back(mk(32'h300 + 32'(4 * i), SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'd0));
    for (int i = 0; i < 2; i++)
      iq.push_back(mk(32'h400 + 32'(4 * i), SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'd0));
    hist = '0;
    run(1);
    chk("prio_pattern", {12'd0, hist[19:0]}, 32'hAA6A9);

    // Randomized traffic on both instances
    for (int r = 0; r < 3; r++) begin
      push_random(20, 30);
      run(0);
      push_random(25, 25);
      run(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
